// File: rtl/tt_um_sorta_alu_aria_mitra.sv
// tt_um_sorta_alu_aria_mitra: registered 4-bit ALU tile with an 8-bit result.
// Operands A = ui_in[7:4], B = ui_in[3:0]; opcode = uio_in[3:0].
// Result R on uo_out, flags {Z,C,N,V} on uio_out[7:4], one cycle after sampling.
// Optional build macro SORTA_ALU_SAT_EN: ADD saturates to 0x0F on carry and
// SUB saturates to 0x00 on borrow (V still reflects the unsaturated value).
// rst_n is, despite its name, a synchronous active-high reset.

module tt_um_sorta_alu_aria_mitra (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NAND = 4'h5,
    OP_NOR  = 4'h6,
    OP_XNOR = 4'h7,
    OP_MUL  = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_ROL  = 4'hB,
    OP_CMP  = 4'hC,
    OP_MAX  = 4'hD,
    OP_MIN  = 4'hE,
    OP_POP  = 4'hF
  } op_t;

  // Number of set bits in a byte (0..8).
  function automatic logic [7:0] popcount8(input logic [7:0] v);
    logic [7:0] cnt;
    cnt = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {7'd0, v[i]};
    end
    return cnt;
  endfunction

  // Last bit pushed out of the top of a 4-bit left shift; 0 for a zero shift.
  function automatic logic shl_carry(input logic [3:0] a, input logic [1:0] s);
    logic [1:0] idx;
    idx = 2'd0 - s;           // 4 - s, modulo 4: s=1->3, s=2->2, s=3->1
    if (s == 2'd0) begin
      return 1'b0;
    end else begin
      return a[idx];
    end
  endfunction

  // Last bit pushed out of the bottom of a 4-bit logical right shift; 0 for a zero shift.
  function automatic logic shr_carry(input logic [3:0] a, input logic [1:0] s);
    logic [1:0] idx;
    idx = s - 2'd1;           // s=1->0, s=2->1, s=3->2
    if (s == 2'd0) begin
      return 1'b0;
    end else begin
      return a[idx];
    end
  endfunction

  // 4-bit rotate left by 0..3.
  function automatic logic [3:0] rol4(input logic [3:0] a, input logic [1:0] s);
    logic [7:0] dbl;
    dbl = {a, a} << s;
    return dbl[7:4];
  endfunction

  logic [3:0] a_s;
  logic [3:0] b_s;
  op_t        op_s;
  logic [4:0] sum_s;
  logic [4:0] diff_s;
  logic [7:0] res_s;
  logic       c_s;
  logic       v_s;
  logic       z_s;
  logic       n_s;
  logic [7:0] result_r;
  logic [3:0] flags_r;
  logic       unused_s;

  assign a_s    = ui_in[7:4];
  assign b_s    = ui_in[3:0];
  assign op_s   = op_t'(uio_in[3:0]);
  assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
  assign diff_s = {1'b0, a_s} - {1'b0, b_s};

  // Upper uio_in bits carry no meaning for this tile.
  assign unused_s = &{uio_in[7:4], 1'b0};

  // Combinational ALU: next result plus carry/overflow for the sampled opcode.
  always_comb begin
    res_s = 8'h00;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (op_s)
      OP_ADD: begin
        res_s = {3'b000, sum_s};
        c_s   = sum_s[4];
        v_s   = (a_s[3] == b_s[3]) && (sum_s[3] != a_s[3]);
`ifdef SORTA_ALU_SAT_EN
        if (sum_s[4]) begin
          res_s = 8'h0F;
        end else begin
          res_s = {3'b000, sum_s};
        end
`endif
      end
      OP_SUB: begin
        res_s = {4'h0, diff_s[3:0]};
        c_s   = (a_s < b_s);
        v_s   = (a_s[3] != b_s[3]) && (diff_s[3] != a_s[3]);
`ifdef SORTA_ALU_SAT_EN
        if (a_s < b_s) begin
          res_s = 8'h00;
        end else begin
          res_s = {4'h0, diff_s[3:0]};
        end
`endif
      end
      OP_AND:  res_s = {4'h0, a_s & b_s};
      OP_OR:   res_s = {4'h0, a_s | b_s};
      OP_XOR:  res_s = {4'h0, a_s ^ b_s};
      OP_NAND: res_s = {4'h0, ~(a_s & b_s)};
      OP_NOR:  res_s = {4'h0, ~(a_s | b_s)};
      OP_XNOR: res_s = {4'h0, ~(a_s ^ b_s)};
      OP_MUL:  res_s = {4'h0, a_s} * {4'h0, b_s};
      OP_SHL: begin
        res_s = {4'h0, a_s << b_s[1:0]};
        c_s   = shl_carry(a_s, b_s[1:0]);
      end
      OP_SHR: begin
        res_s = {4'h0, a_s >> b_s[1:0]};
        c_s   = shr_carry(a_s, b_s[1:0]);
      end
      OP_ROL:  res_s = {4'h0, rol4(a_s, b_s[1:0])};
      OP_CMP:  res_s = {5'b00000, (a_s > b_s), (a_s == b_s), (a_s < b_s)};
      OP_MAX: begin
        if (a_s > b_s) begin
          res_s = {4'h0, a_s};
        end else begin
          res_s = {4'h0, b_s};
        end
      end
      OP_MIN: begin
        if (a_s < b_s) begin
          res_s = {4'h0, a_s};
        end else begin
          res_s = {4'h0, b_s};
        end
      end
      OP_POP:  res_s = popcount8(ui_in);
      default: res_s = 8'h00;
    endcase
  end

  // Zero and negative always follow the final (possibly saturated) result.
  assign z_s = (res_s == 8'h00);
  assign n_s = res_s[7];

  // Result/flag registers: reset first, then load when enabled, else hold.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      result_r <= 8'h00;
      flags_r  <= 4'h0;
    end else if (ena) begin
      result_r <= res_s;
      flags_r  <= {z_s, c_s, n_s, v_s};
    end else begin
      result_r <= result_r;
      flags_r  <= flags_r;
    end
  end

  assign uo_out  = result_r;
  assign uio_out = {flags_r, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_sorta_alu_aria_mitra.sv
// Directed bench for tt_um_sorta_alu_aria_mitra; expected values are hand-computed.
// Flag byte on uio_out is {Z,C,N,V,4'b0}.

module tb_tt_um_sorta_alu_aria_mitra;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  tt_um_sorta_alu_aria_mitra dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic [7:0] ui, input logic [7:0] uio);
    ui_in  = ui;
    uio_in = uio;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'h08;

    // Reset held for two edges with a MUL pending on the inputs.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    check("reset_oe", uio_oe, 8'hF0);

    rst_n = 1'b0;

    step(8'h98, 8'h00);
`ifdef SORTA_ALU_SAT_EN
    check("add_carry_uo", uo_out, 8'h0F);
`else
    check("add_carry_uo", uo_out, 8'h11);
`endif
    check("add_carry_flags", uio_out, 8'h50);

    step(8'h44, 8'h00);
    check("add_ovf_uo", uo_out, 8'h08);
    check("add_ovf_flags", uio_out, 8'h10);

    step(8'h35, 8'h01);
`ifdef SORTA_ALU_SAT_EN
    check("sub_borrow_uo", uo_out, 8'h00);
    check("sub_borrow_flags", uio_out, 8'hC0);
`else
    check("sub_borrow_uo", uo_out, 8'h0E);
    check("sub_borrow_flags", uio_out, 8'h40);
`endif

    step(8'h55, 8'h01);
    check("sub_zero_uo", uo_out, 8'h00);
    check("sub_zero_flags", uio_out, 8'h80);

    // MUL: result is not visible before the edge, then appears one cycle later.
    ui_in  = 8'hFF;
    uio_in = 8'h08;
    #1;
    check("mul_latency_uo", uo_out, 8'h00);
    @(posedge clk);
    #1;
    check("mul_uo", uo_out, 8'hE1);
    check("mul_flags", uio_out, 8'h20);

    step(8'h6C, 8'hF2);
    check("and_hi_op_ignored", uo_out, 8'h04);

    step(8'hF0, 8'h05);
    check("nand_uo", uo_out, 8'h0F);

    step(8'h77, 8'h0C);
    check("cmp_eq_uo", uo_out, 8'h02);
    check("cmp_flags", uio_out, 8'h00);

    step(8'hF3, 8'h0F);
    check("popcnt_uo", uo_out, 8'h06);

    step(8'hC2, 8'h09);
    check("shl_carry_uo", uo_out, 8'h00);
    check("shl_carry_flags", uio_out, 8'hC0);

    step(8'h90, 8'h09);
    check("shl_zero_shift_uo", uo_out, 8'h09);
    check("shl_zero_shift_flags", uio_out, 8'h00);

    step(8'hB2, 8'h0A);
    check("shr_uo", uo_out, 8'h02);
    check("shr_flags", uio_out, 8'h40);

    step(8'h93, 8'h0B);
    check("rol_uo", uo_out, 8'h0C);

    step(8'h3A, 8'h0D);
    check("max_uo", uo_out, 8'h0A);

    step(8'h3A, 8'h0E);
    check("min_uo", uo_out, 8'h03);

    step(8'h93, 8'h09);
    check("shl_uo", uo_out, 8'h08);

    // Hold with ena low while inputs change.
    ena = 1'b0;
    step(8'h98, 8'h00);
    check("hold_uo", uo_out, 8'h08);
    step(8'h55, 8'h01);
    check("hold_uo_2", uo_out, 8'h08);

    // Reset wins over a disabled tile.
    rst_n = 1'b1;
    step(8'hFF, 8'h08);
    check("reset_over_ena_uo", uo_out, 8'h00);
    check("reset_over_ena_uio", uio_out, 8'h00);

    // Reset asserted mid-stream discards the pending result.
    rst_n = 1'b0;
    ena   = 1'b1;
    step(8'hFF, 8'h08);
    check("pre_reset_mul_uo", uo_out, 8'hE1);
    rst_n = 1'b1;
    step(8'h98, 8'h00);
    check("midstream_reset_uo", uo_out, 8'h00);
    check("midstream_reset_oe", uio_oe, 8'hF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
